// File: rtl/mem_pkg.sv
// Shared opcode constants, state encoding and opcode decode for the memory-stage access unit.
package mem_pkg;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LDR = 5'b01000;
  localparam logic [4:0] OP_STR = 5'b01001;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  function automatic logic is_mem_op(input logic [4:0] opcode);
    return (opcode == OP_LDR) || (opcode == OP_STR);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues LDR/STR on a req/ack port, stalls upstream while a
// transaction is outstanding, and emits one registered result per instruction to MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        OpCode,
  input  logic [6:0]        CurrentAddress,
  input  logic [31:0]       ResultAlu,
  input  logic [31:0]       StoreData,
  output logic              Stall,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  input  logic [31:0]       MemRData,
  input  logic              MemAck,
  output logic [4:0]        OpCodeOut,
  output logic [6:0]        CurrentAddressOut,
  output logic [31:0]       ResultOut,
  output logic              ValidOut,
  output logic              MemError
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mem_op;
  logic             cnt_last;

  assign mem_op   = is_mem_op(OpCode);
  assign cnt_last = (cnt == CNT_LAST);

  // Upstream holds while a memory op waits to issue or waits for ack; the ack or
  // timeout cycle releases it so the next instruction arrives as this one retires.
  always_comb begin
    Stall = 1'b0;
    case (state)
      IDLE:    Stall = mem_op;
      WAIT:    Stall = !MemAck && !cnt_last;
      default: Stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      MemReq            <= 1'b0;
      MemWe             <= 1'b0;
      MemAddr           <= '0;
      MemWData          <= '0;
      OpCodeOut         <= OP_NOP;
      CurrentAddressOut <= '0;
      ResultOut         <= '0;
      ValidOut          <= 1'b0;
      MemError          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state     <= WAIT;
            cnt       <= '0;
            MemReq    <= 1'b1;
            MemWe     <= (OpCode == OP_STR);
            MemAddr   <= ResultAlu[ADDR_W-1:0];
            MemWData  <= StoreData;
            OpCodeOut <= OP_NOP;
            ValidOut  <= 1'b0;
          end else begin
            OpCodeOut         <= OpCode;
            CurrentAddressOut <= CurrentAddress;
            ResultOut         <= ResultAlu;
            ValidOut          <= (OpCode != OP_NOP);
          end
        end
        WAIT: begin
          // Inputs are frozen by Stall, so the retiring instruction is read straight from them.
          if (MemAck) begin
            state             <= IDLE;
            MemReq            <= 1'b0;
            OpCodeOut         <= OpCode;
            CurrentAddressOut <= CurrentAddress;
            ResultOut         <= (OpCode == OP_LDR) ? MemRData : ResultAlu;
            ValidOut          <= 1'b1;
          end else if (cnt_last) begin
            state             <= IDLE;
            MemReq            <= 1'b0;
            MemError          <= 1'b1;
            OpCodeOut         <= OpCode;
            CurrentAddressOut <= CurrentAddress;
            ResultOut         <= '0;
            ValidOut          <= 1'b1;
          end else begin
            cnt       <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            OpCodeOut <= OP_NOP;
            ValidOut  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, LDR/STR handshakes, timeout,
// stray/coincident acks and reset in the middle of a transaction.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  OpCode;
  logic [6:0]  CurrentAddress;
  logic [31:0] ResultAlu;
  logic [31:0] StoreData;
  logic        Stall;
  logic        MemReq;
  logic        MemWe;
  logic [9:0]  MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;
  logic [4:0]  OpCodeOut;
  logic [6:0]  CurrentAddressOut;
  logic [31:0] ResultOut;
  logic        ValidOut;
  logic        MemError;

  int checks   = 0;
  int failures = 0;
  int stall_cnt;
  int req_cnt;

  mem_access_unit #(.ADDR_W(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .CurrentAddress(CurrentAddress),
    .ResultAlu(ResultAlu), .StoreData(StoreData), .Stall(Stall), .MemReq(MemReq),
    .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
    .MemAck(MemAck), .OpCodeOut(OpCodeOut), .CurrentAddressOut(CurrentAddressOut),
    .ResultOut(ResultOut), .ValidOut(ValidOut), .MemError(MemError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] op, input logic [6:0] pc, input logic [31:0] alu,
                        input logic [31:0] sd);
    OpCode = op; CurrentAddress = pc; ResultAlu = alu; StoreData = sd;
  endtask

  initial begin
    rst_n = 1'b0; MemAck = 1'b0; MemRData = '0;
    set_in(5'b00000, 7'h00, 32'h0, 32'h0);
    #12;
    chk("rst_memreq", MemReq, 0);
    chk("rst_valid", ValidOut, 0);
    chk("rst_opout", OpCodeOut, 0);
    chk("rst_result", ResultOut, 0);
    chk("rst_memerr", MemError, 0);
    chk("rst_stall", Stall, 0);
    rst_n = 1'b1;
    tick();

    // ALU pass-through
    set_in(5'b00011, 7'h05, 32'h1234, 32'h0);
    #1 chk("alu_stall_pre", Stall, 0);
    tick();
    chk("alu_valid", ValidOut, 1);
    chk("alu_result", ResultOut, 32'h1234);
    chk("alu_opout", OpCodeOut, 5'b00011);
    chk("alu_pc", CurrentAddressOut, 7'h05);
    chk("alu_stall", Stall, 0);

    // LDR, ack after 3 WAIT cycles
    set_in(5'b01000, 7'h06, 32'h0000_0010, 32'h0);
    MemRData = 32'hCAFEF00D;
    stall_cnt = 0;
    #1 if (Stall) stall_cnt++;
    tick();
    chk("ldr_memreq", MemReq, 1);
    chk("ldr_memwe", MemWe, 0);
    chk("ldr_addr", MemAddr, 10'h010);
    chk("ldr_bubble_valid", ValidOut, 0);
    chk("ldr_bubble_op", OpCodeOut, 0);
    for (int i = 0; i < 3; i++) begin
      if (Stall) stall_cnt++;
      tick();
    end
    MemAck = 1'b1;
    #1 if (Stall) stall_cnt++;
    chk("ldr_stall_cycles", stall_cnt, 4);
    tick();
    MemAck = 1'b0;
    set_in(5'b00000, 7'h00, 32'h0, 32'h0);
    chk("ldr_valid", ValidOut, 1);
    chk("ldr_result", ResultOut, 32'hCAFEF00D);
    chk("ldr_opout", OpCodeOut, 5'b01000);
    chk("ldr_pc", CurrentAddressOut, 7'h06);
    chk("ldr_req_drop", MemReq, 0);

    // STR, ack in first WAIT cycle
    set_in(5'b01001, 7'h07, 32'h0000_0123, 32'hA5A5A5A5);
    tick();
    chk("str_memreq", MemReq, 1);
    chk("str_memwe", MemWe, 1);
    chk("str_wdata", MemWData, 32'hA5A5A5A5);
    chk("str_addr", MemAddr, 10'h123);
    MemAck = 1'b1;
    #1 chk("str_stall_ack", Stall, 0);
    tick();
    MemAck = 1'b0;
    set_in(5'b00000, 7'h00, 32'h0, 32'h0);
    chk("str_req_one_cycle", MemReq, 0);
    chk("str_result", ResultOut, 32'h0000_0123);
    chk("str_valid", ValidOut, 1);

    // Stray ack in IDLE
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    chk("idle_ack_req", MemReq, 0);
    chk("idle_ack_valid", ValidOut, 0);
    chk("idle_ack_err", MemError, 0);

    // Ack coincident with the timeout cycle
    set_in(5'b01000, 7'h08, 32'h0000_0020, 32'h0);
    MemRData = 32'h11112222;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("coin_req_held", MemReq, 1);
    MemAck = 1'b1;
    #1 chk("coin_stall", Stall, 0);
    tick();
    MemAck = 1'b0;
    set_in(5'b00000, 7'h00, 32'h0, 32'h0);
    chk("coin_result", ResultOut, 32'h11112222);
    chk("coin_valid", ValidOut, 1);
    chk("coin_err", MemError, 0);
    chk("coin_req_drop", MemReq, 0);

    // Timeout: no ack at all
    set_in(5'b01000, 7'h09, 32'h0000_0030, 32'h0);
    tick();
    req_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!MemReq) break;
      if (k == 15) chk("to_stall_last", Stall, 0);
      req_cnt++;
      tick();
    end
    chk("to_req_cycles", req_cnt, 16);
    chk("to_err", MemError, 1);
    chk("to_valid", ValidOut, 1);
    chk("to_result", ResultOut, 0);
    chk("to_opout", OpCodeOut, 5'b01000);
    set_in(5'b00100, 7'h0A, 32'h0000_0077, 32'h0);
    tick();
    chk("post_to_valid", ValidOut, 1);
    chk("post_to_result", ResultOut, 32'h77);
    chk("err_sticky", MemError, 1);

    // Reset in the 2nd WAIT cycle
    set_in(5'b01000, 7'h0B, 32'h0000_0040, 32'h0);
    tick();
    tick();
    chk("mid_req_before", MemReq, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", MemReq, 0);
    chk("mid_rst_valid", ValidOut, 0);
    chk("mid_rst_op", OpCodeOut, 0);
    chk("mid_rst_result", ResultOut, 0);
    chk("mid_rst_err", MemError, 0);
    chk("mid_rst_addr", MemAddr, 0);
    set_in(5'b01000, 7'h0C, 32'h0000_0044, 32'h0);
    MemRData = 32'hDEADBEEF;
    #2 rst_n = 1'b1;
    tick();
    chk("after_rst_req", MemReq, 1);
    chk("after_rst_addr", MemAddr, 10'h044);
    MemAck = 1'b1;
    tick();
    MemAck = 1'b0;
    set_in(5'b00000, 7'h00, 32'h0, 32'h0);
    chk("after_rst_result", ResultOut, 32'hDEADBEEF);
    chk("after_rst_valid", ValidOut, 1);
    chk("after_rst_pc", CurrentAddressOut, 7'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
